apb_regbank: RTL and testbench

APB slave register bank that terminates the master-side APB bus of the passthrough stage, inserting a fixed number of wait states per transfer. It holds a read-only ID word, a read-only transfer counter and a set of byte-strobed read/write registers whose contents are exported flat to downstream logic. There is no PSLVERR: every transfer completes, and out-of-range accesses are silently absorbed.

---
 rtl/apb_regbank.sv | 173 +++++++++++++++++
 tb/tb_apb_regbank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regbank.sv
// APB slave register bank: read-only ID word, read-only transfer counter and
// byte-strobed R/W words, with a fixed number of wait states per transfer.
module apb_regbank #(
  parameter int unsigned             G_REGWIDTH    = 32,
  parameter int unsigned             G_ADDR_WIDTH  = 32,
  parameter int unsigned             G_NUM_REGS    = 16,
  parameter int unsigned             G_WAIT_CYCLES = 2,
  parameter logic [G_REGWIDTH-1:0]   G_ID          = 32'hA9B0_0001
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_apb_psel,
  input  logic                               s_apb_penable,
  input  logic                               s_apb_pwrite,
  input  logic [2:0]                         s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0]            s_apb_paddr,
  input  logic [G_REGWIDTH-1:0]              s_apb_pwdata,
  input  logic [G_REGWIDTH/8-1:0]            s_apb_pstrb,
  output logic                               s_apb_pready,
  output logic [G_REGWIDTH-1:0]              s_apb_prdata,
  output logic [G_NUM_REGS*G_REGWIDTH-1:0]   regs_o
);

  localparam int          NB        = G_REGWIDTH / 8;
  localparam int unsigned ADDR_LSB  = $clog2(NB);
  localparam logic [3:0]  WAIT_INIT = (G_WAIT_CYCLES == 0) ? 4'd0 : 4'(G_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [G_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    write_q, write_d;
  logic [G_REGWIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           strb_q, strb_d;
  logic [G_REGWIDTH-1:0]   prdata_q, prdata_d;
  logic [G_REGWIDTH-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic [G_REGWIDTH-1:0]   rw_q [2:G_NUM_REGS-1];
  logic [G_REGWIDTH-1:0]   rw_d [2:G_NUM_REGS-1];

  logic [G_ADDR_WIDTH-1:0] acc_addr;
  logic [G_ADDR_WIDTH-1:0] acc_idx;
  logic                    acc_write;
  logic [G_REGWIDTH-1:0]   rd_word;
  logic                    load_rd;

  logic unused_pprot;
  assign unused_pprot = ^s_apb_pprot;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prdata_d   = '0;
    xfer_cnt_d = xfer_cnt_q;
    rw_d       = rw_q;
    load_rd    = 1'b0;

    // In IDLE the zero-wait path decodes the live bus; later states use the capture.
    acc_addr  = (state_q == S_IDLE) ? s_apb_paddr  : addr_q;
    acc_write = (state_q == S_IDLE) ? s_apb_pwrite : write_q;
    acc_idx   = acc_addr >> ADDR_LSB;

    rd_word = '0;
    if (acc_idx == '0) begin
      rd_word = G_ID;
    end else if (acc_idx == G_ADDR_WIDTH'(1)) begin
      rd_word = xfer_cnt_q;
    end else begin
      for (int n = 2; n < G_NUM_REGS; n++) begin
        if (acc_idx == G_ADDR_WIDTH'(n)) rd_word = rw_q[n];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (s_apb_psel && !s_apb_penable) begin
          addr_d  = s_apb_paddr;
          write_d = s_apb_pwrite;
          wdata_d = s_apb_pwdata;
          strb_d  = s_apb_pstrb;
          if (G_WAIT_CYCLES == 0) begin
            state_d = S_READY;
            load_rd = 1'b1;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!s_apb_psel) begin
          state_d = S_IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = S_READY;
          load_rd = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_READY: begin
        prdata_d = prdata_q;
        if (s_apb_psel && s_apb_penable) begin
          state_d    = S_IDLE;
          prdata_d   = '0;
          xfer_cnt_d = xfer_cnt_q + G_REGWIDTH'(1);
          if (write_q) begin
            for (int n = 2; n < G_NUM_REGS; n++) begin
              if (acc_idx == G_ADDR_WIDTH'(n)) begin
                for (int k = 0; k < NB; k++) begin
                  if (strb_q[k]) rw_d[n][k*8 +: 8] = wdata_q[k*8 +: 8];
                end
              end
            end
          end
        end else if (!s_apb_psel) begin
          state_d  = S_IDLE;
          prdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_rd && !acc_write) prdata_d = rd_word;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 4'd0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prdata_q   <= '0;
      xfer_cnt_q <= '0;
      // NOTE: the R/W words are architecturally visible with a defined reset
      // value, so this small array is reset like ordinary flops.
      for (int n = 2; n < G_NUM_REGS; n++) rw_q[n] <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      prdata_q   <= prdata_d;
      xfer_cnt_q <= xfer_cnt_d;
      rw_q       <= rw_d;
    end
  end

  assign s_apb_pready = (state_q == S_READY);
  assign s_apb_prdata = prdata_q;

  assign regs_o[0 +: G_REGWIDTH]          = G_ID;
  assign regs_o[G_REGWIDTH +: G_REGWIDTH] = xfer_cnt_q;
  for (genvar n = 2; n < G_NUM_REGS; n++) begin : g_regs_out
    assign regs_o[n*G_REGWIDTH +: G_REGWIDTH] = rw_q[n];
  end

endmodule

// File: tb/tb_apb_regbank.sv
// Scoreboard bench for apb_regbank: unit 0 built with two wait states, unit 1
// with zero wait states, both checked against an array-based register model.
module tb_apb_regbank;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       psel = '0, penable = '0, pwrite = '0;
  logic [1:0][2:0]  pprot = '0;
  logic [1:0][31:0] paddr = '0, pwdata = '0;
  logic [1:0][3:0]  pstrb = '0;
  logic [1:0]       pready;
  logic [1:0][31:0] prdata;
  logic [1:0][511:0] regs;

  always #5 clk = ~clk;

  apb_regbank #(.G_WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .s_apb_psel(psel[0]), .s_apb_penable(penable[0]), .s_apb_pwrite(pwrite[0]),
    .s_apb_pprot(pprot[0]), .s_apb_paddr(paddr[0]), .s_apb_pwdata(pwdata[0]),
    .s_apb_pstrb(pstrb[0]), .s_apb_pready(pready[0]), .s_apb_prdata(prdata[0]),
    .regs_o(regs[0])
  );

  apb_regbank #(.G_WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_apb_psel(psel[1]), .s_apb_penable(penable[1]), .s_apb_pwrite(pwrite[1]),
    .s_apb_pprot(pprot[1]), .s_apb_paddr(paddr[1]), .s_apb_pwdata(pwdata[1]),
    .s_apb_pstrb(pstrb[1]), .s_apb_pready(pready[1]), .s_apb_prdata(prdata[1]),
    .regs_o(regs[1])
  );

  // Reference model: plain word arrays plus a transfer count per unit.
  logic [31:0] mdl  [2][16];
  logic [31:0] mcnt [2];

  typedef struct {
    int          unit;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int u, input logic [31:0] addr);
    logic [31:0] idx = addr >> 2;
    if (idx == 0) return ID;
    if (idx == 1) return mcnt[u];
    if (idx < 16) return mdl[u][idx];
    return 32'h0;
  endfunction

  task automatic model_write(input int u, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] idx = addr >> 2;
    if (idx >= 2 && idx < 16)
      for (int k = 0; k < 4; k++)
        if (st[k]) mdl[u][idx][k*8 +: 8] = wd[k*8 +: 8];
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mcnt[u] = 32'h0;
      for (int w = 0; w < 16; w++) mdl[u][w] = 32'h0;
    end
  endtask

  task automatic check_regs(input int u);
    logic [31:0] exp;
    for (int w = 0; w < 16; w++) begin
      exp = (w == 0) ? ID : (w == 1) ? mcnt[u] : mdl[u][w];
      check($sformatf("regs_o_u%0d_w%0d", u, w), regs[u][w*32 +: 32], exp);
    end
  endtask

  // Entered and left #1 after a rising edge; the entry cycle is the setup phase.
  // mode 0: normal, 1: drop psel during WAIT, 2: async reset while READY.
  task automatic xfer(input int u, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input int mode);
    int   wc  = (u == 0) ? 2 : 0;
    int   lat = 0;
    exp_t e;
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr;
    paddr[u] = addr; pwdata[u] = wd; pstrb[u] = st; pprot[u] = 3'($urandom);
    if (mode != 1) begin
      e.unit = u;
      e.data = wr ? 32'h0 : model_read(u, addr);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    penable[u] = 1'b1;
    pwdata[u]  = $urandom;
    pstrb[u]   = 4'($urandom);
    if (mode == 1) begin
      @(posedge clk); #1;
      psel[u] = 1'b0; penable[u] = 1'b0;
      repeat (4) begin
        @(negedge clk);
        check($sformatf("abort_no_pready_u%0d", u), pready[u], 1'b0);
      end
      @(posedge clk); #1;
      return;
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (pready[u]) begin
        lat = k;
        break;
      end
    end
    check($sformatf("pready_latency_u%0d", u), lat, 1 + wc);
    if (mode == 2) begin
      #1 rst = 1'b1;
      #1;
      check("pready_async_rst", pready[u], 1'b0);
      check("prdata_async_rst", prdata[u], 32'h0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0; psel[u] = 1'b0; penable[u] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    psel[u] = 1'b0; penable[u] = 1'b0;
    mcnt[u] = mcnt[u] + 1;
    if (wr) model_write(u, addr, wd, st);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation for every cycle a unit shows pready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (pready[u] === 1'b1) begin
          check($sformatf("pending_xfer_u%0d", u), exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pready_unit", u, e.unit);
            check($sformatf("prdata_u%0d", u), prdata[u], e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    model_reset();
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_pready_u%0d", u), pready[u], 1'b0);
      check($sformatf("reset_prdata_u%0d", u), prdata[u], 32'h0);
      check_regs(u);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Unit 0, two wait states.
    xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 0);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 0);
    idle(1);
    xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'b0101, 0);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 0);
    check("word2_strobed", regs[0][2*32 +: 32], 32'h00AD_00EF);
    xfer(0, 1'b1, 32'h00, 32'h1234_5678, 4'hF, 0);
    xfer(0, 1'b1, 32'h04, 32'h1234_5678, 4'hF, 0);
    xfer(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 0);
    xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 0);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 0);
    check("counter_after_9", regs[0][1*32 +: 32], 32'd9);
    check_regs(0);

    xfer(0, 1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF, 1);
    check("abort_word3", regs[0][3*32 +: 32], 32'h0);
    check_regs(0);
    xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 32'h4F);
      d = $urandom;
      s = 4'($urandom);
      xfer(0, 1'($urandom), a, d, s, 0);
      idle($urandom_range(0, 2));
    end
    check_regs(0);

    xfer(0, 1'b1, 32'h10, 32'h5555_AAAA, 4'hF, 2);
    check_regs(0);
    check_regs(1);
    idle(1);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 0);

    // Unit 1, zero wait states, back-to-back transfers.
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(2, 15)) << 2;
      d = $urandom;
      s = 4'($urandom);
      xfer(1, 1'($urandom), a, d, s, 0);
    end
    check_regs(1);

    force dut0.xfer_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut0.xfer_cnt_q;
    mcnt[1] = 32'hFFFF_FFFE;
    repeat (3) xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 0);
    check("counter_wrapped", regs[1][1*32 +: 32], 32'd1);
    check_regs(1);

    idle(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
